cim_ctrl: RTL
=============

CIM_CTRL -- requirements
Module: cim_ctrl

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, array data width in bits.
REQ-002 SHALL have parameter AWIDTH, default 12, array address width in bits.
REQ-003 SHALL have parameter LWIDTH, default 8, burst length field width; a burst is cmd_len+1 beats.
REQ-004 SHALL have ports: clk in 1, rising-edge clock; rst_n in 1, synchronous active-low reset.
REQ-005 SHALL have command ports: cmd_valid in 1; cmd_ready out 1; cmd_op in 2 (00 WRITE, 01 READ, 10 COMPUTE, 11 illegal); cmd_addr in AWIDTH, start address; cmd_len in LWIDTH; cmd_func in 4, CIM function code.
REQ-006 SHALL have write-data ports: wdata_valid in 1; wdata_ready out 1; wdata in DWIDTH.
REQ-007 SHALL have read-data ports: rdata_valid out 1; rdata_ready in 1; rdata out DWIDTH, carrying READ data or COMPUTE results.
REQ-008 SHALL have status ports: done out 1, one-cycle pulse at burst end; err out 1, one-cycle pulse on illegal op; busy out 1.
REQ-009 SHALL have array-side ports: arr_addr out AWIDTH; arr_din out DWIDTH; arr_dout in DWIDTH; arr_we out 1; arr_oe out 1; arr_cme out 1; arr_func out 4.

Function
REQ-010 SHALL implement FSM states IDLE, WR, RD, CMP, DRAIN; cmd_ready=1 only in IDLE; a command is accepted on cmd_valid&&cmd_ready.
REQ-011 SHALL latch addr, len, func and op on acceptance; go to WR/RD/CMP next cycle; on op 11, pulse err and done next cycle and stay in IDLE with no array access.
REQ-012 SHALL in WR drive wdata_ready=1 and, per wdata handshake, assert arr_we=1 with arr_addr=current address and arr_din=wdata in the same cycle (combinational pass-through, zero latency).
REQ-013 SHALL in RD issue arr_oe=1 for one beat per cycle only when the read buffer has a free slot counting the in-flight beat; arr_dout is sampled exactly one cycle after arr_oe.
REQ-014 SHALL in CMP behave as RD but additionally hold arr_cme=1 and arr_func=latched func on every issue cycle; arr_cme=0 and arr_func=0 otherwise.
REQ-015 SHALL increment the address after every issued beat, wrapping from 2^AWIDTH-1 to 0.
REQ-016 SHALL, after the last write beat, pulse done and return to IDLE in the following cycle.
REQ-017 SHALL, after the last read/compute issue, enter DRAIN and stay until the buffer is empty and nothing is in flight, then pulse done and return to IDLE.
REQ-018 SHALL buffer read results in a 2-entry FIFO; rdata_valid = FIFO non-empty; pop on rdata_valid&&rdata_ready; push and pop in the same cycle are legal; no beat is ever dropped or duplicated.
REQ-019 SHALL never assert arr_we together with arr_oe or arr_cme.
REQ-020 SHALL drive busy=1 in every state except IDLE.

Reset
REQ-021 SHALL on rst_n=0 at a clock edge: FSM to IDLE, FIFO flushed, in-flight beat discarded; all outputs 0 except cmd_ready=1.
REQ-022 SHALL abandon a burst interrupted by reset with no done pulse; the first command after reset is accepted normally.

Configuration
REQ-023 SHALL with macro CIM_CTRL_PERF_EN defined provide output perf_cnt (32 bits) counting cycles with busy=1, saturating at 0xFFFFFFFF, cleared by reset.
REQ-024 SHALL without CIM_CTRL_PERF_EN keep port perf_cnt and tie it to 0, with no counter logic.

Structure
REQ-025 SHALL place op encodings, FSM state encoding and default widths in shared package cim_pkg.
REQ-026 SHALL implement the 2-entry read FIFO as sub-module cim_ctrl_skid, parameterised by DWIDTH.

Verification
REQ-027 WRITE addr=0x010 len=3, data 0xA0..0xA3 back-to-back -> arr_we on 4 cycles, addresses 0x010..0x013, then done.
REQ-028 READ addr=0x010 len=3 with rdata_ready=1 -> rdata 0xA0..0xA3 in order, one per cycle after a 1-cycle array latency, then done.
REQ-029 READ len=7 with rdata_ready toggling 1/0 -> exactly 8 beats in order, arr_oe stalls while the FIFO is full.
REQ-030 COMPUTE addr=0xFFE len=3 func=0x5 -> arr_cme=1 and arr_func=0x5 on issue cycles, addresses 0xFFE,0xFFF,0x000,0x001.
REQ-031 cmd_op=11 -> err and done pulse together, no arr_we/arr_oe/arr_cme activity.
REQ-032 rst_n=0 mid-READ with 1 beat buffered -> next cycle all outputs 0, cmd_ready=1, no done pulse.

Source files
------------

// File: rtl/cim_pkg.sv
// Shared encodings for the CIM controller: command opcodes, FSM states and
// default widths.
package cim_pkg;

  localparam int DWIDTH_DEF = 32;
  localparam int AWIDTH_DEF = 12;
  localparam int LWIDTH_DEF = 8;

  typedef enum logic [1:0] {
    OP_WRITE   = 2'b00,
    OP_READ    = 2'b01,
    OP_COMPUTE = 2'b10,
    OP_ILLEGAL = 2'b11
  } cim_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WR    = 3'd1,
    ST_RD    = 3'd2,
    ST_CMP   = 3'd3,
    ST_DRAIN = 3'd4
  } cim_state_e;

endpackage

// File: rtl/cim_ctrl_skid.sv
// Two-entry read-result FIFO; a push and a pop may occur in the same cycle.
// Output data reads as zero while the FIFO is empty.
module cim_ctrl_skid #(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [DWIDTH-1:0] i_push_data,
  input  logic              i_pop,
  output logic              o_valid,
  output logic [DWIDTH-1:0] o_data,
  output logic [1:0]        o_count
);

  logic [DWIDTH-1:0] r_mem [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;
  logic              w_pop;
  logic              w_push;

  assign w_pop  = i_pop && (r_count != 2'd0);
  assign w_push = i_push && ((r_count != 2'd2) || w_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign o_valid = (r_count != 2'd0);
  assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;
  assign o_count = r_count;

endmodule

// File: rtl/cim_ctrl.sv
// Compute-in-memory array controller: WRITE/READ/COMPUTE bursts against a
// 1-cycle-latency array. Optional busy-cycle counter under CIM_CTRL_PERF_EN.
module cim_ctrl
  import cim_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int LWIDTH = LWIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [AWIDTH-1:0] cmd_addr,
  input  logic [LWIDTH-1:0] cmd_len,
  input  logic [3:0]        cmd_func,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DWIDTH-1:0] wdata,
  output logic              rdata_valid,
  input  logic              rdata_ready,
  output logic [DWIDTH-1:0] rdata,
  output logic              done,
  output logic              err,
  output logic              busy,
  output logic [AWIDTH-1:0] arr_addr,
  output logic [DWIDTH-1:0] arr_din,
  input  logic [DWIDTH-1:0] arr_dout,
  output logic              arr_we,
  output logic              arr_oe,
  output logic              arr_cme,
  output logic [3:0]        arr_func,
  output logic [31:0]       perf_cnt,
  output cim_state_e        dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid never waits on ready, and payload must be stable while valid is high.

  cim_state_e        r_state;
  cim_op_e           r_op;
  logic [AWIDTH-1:0] r_addr;
  logic [LWIDTH-1:0] r_len;
  logic [LWIDTH-1:0] r_cnt;
  logic [3:0]        r_func;
  logic              r_done;
  logic              r_err;
  logic              r_inflight;

  logic              w_rd_phase;
  logic              w_issue;
  logic              w_we;
  logic              w_pop;
  logic              w_fifo_valid;
  logic [1:0]        w_fifo_cnt;
  logic [DWIDTH-1:0] w_fifo_data;
  logic [2:0]        w_held;
  logic              w_busy;

  assign w_rd_phase = (r_state == ST_RD) || (r_state == ST_CMP);
  assign w_pop      = w_fifo_valid && rdata_ready;
  // Slots committed next cycle: buffered plus in-flight, minus what leaves now.
  assign w_held     = {1'b0, w_fifo_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue    = w_rd_phase && (w_held < 3'd2);
  assign w_we       = (r_state == ST_WR) && wdata_valid;
  assign w_busy     = (r_state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_op       <= OP_WRITE;
      r_addr     <= '0;
      r_len      <= '0;
      r_cnt      <= '0;
      r_func     <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_inflight <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_inflight <= w_issue;
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_op   <= cim_op_e'(cmd_op);
            r_addr <= cmd_addr;
            r_len  <= cmd_len;
            r_func <= cmd_func;
            r_cnt  <= '0;
            case (cim_op_e'(cmd_op))
              OP_WRITE:   r_state <= ST_WR;
              OP_READ:    r_state <= ST_RD;
              OP_COMPUTE: r_state <= ST_CMP;
              default: begin
                r_done <= 1'b1;
                r_err  <= 1'b1;
              end
            endcase
          end
        end
        ST_WR: begin
          if (w_we) begin
            r_addr <= r_addr + 1'b1;
            r_cnt  <= r_cnt + 1'b1;
            if (r_cnt == r_len) begin
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end
          end
        end
        ST_RD, ST_CMP: begin
          if (w_issue) begin
            r_addr <= r_addr + 1'b1;
            r_cnt  <= r_cnt + 1'b1;
            if (r_cnt == r_len) begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if ((w_fifo_cnt == 2'd0) && !r_inflight) begin
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  cim_ctrl_skid #(.DWIDTH(DWIDTH)) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (r_inflight),
    .i_push_data (arr_dout),
    .i_pop       (w_pop),
    .o_valid     (w_fifo_valid),
    .o_data      (w_fifo_data),
    .o_count     (w_fifo_cnt)
  );

  assign cmd_ready   = (r_state == ST_IDLE);
  assign wdata_ready = (r_state == ST_WR);
  assign rdata_valid = w_fifo_valid;
  assign rdata       = w_fifo_data;
  assign done        = r_done;
  assign err         = r_err;
  assign busy        = w_busy;
  assign arr_we      = w_we;
  assign arr_oe      = w_issue;
  assign arr_cme     = w_issue && (r_op == OP_COMPUTE);
  assign arr_func    = arr_cme ? r_func : 4'h0;
  assign arr_addr    = (w_we || w_issue) ? r_addr : '0;
  assign arr_din     = w_we ? wdata : '0;
  assign dbg_state   = r_state;

`ifdef CIM_CTRL_PERF_EN
  logic [31:0] r_perf;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_perf <= '0;
    end else if (w_busy && (r_perf != 32'hFFFF_FFFF)) begin
      r_perf <= r_perf + 32'd1;
    end
  end
  assign perf_cnt = r_perf;
`else
  assign perf_cnt = 32'd0;
`endif

endmodule
